// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : RV32I front end. Owns the PC, issues one word fetch at a
//                time to instruction memory (valid/ready request, separate
//                response strobe) and presents each fetched instruction with
//                its PC and opcode field to decode over valid/ready.
//                Redirects from execute override everything and squash any
//                fetch that is still in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC        PC loaded on reset (must be 4-byte aligned)
//  Ports
//    clk             core clock, rising edge
//    rst             asynchronous active-high reset
//    imem_req_valid  fetch request valid (forced low while rst is high)
//    imem_req_ready  memory accepts the request
//    imem_req_addr   fetch address
//    imem_rsp_valid  response strobe, one per accepted request
//    imem_rsp_data   fetched instruction word
//    redirect_valid  redirect the PC this cycle (highest priority)
//    redirect_pc     redirect target
//    instr_valid     instruction available to decode
//    instr_ready     decode accepts the instruction
//    instr_data      instruction word
//    instr_pc        PC of instr_data
//    instr_op        instr_data[6:0], opcode for main_decoder
//    instr_fault     misaligned-fetch fault marker
//  Build option
//    FETCH_MISALIGN_TRAP_EN  when defined, a misaligned redirect target makes
//                            no memory request and instead delivers one NOP
//                            beat flagged with instr_fault. When undefined,
//                            the target's low two bits are cleared and
//                            instr_fault is tied low.
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [6:0]  instr_op,
    output logic        instr_fault
);

    localparam int unsigned STATE_W = 2;

    // S_REQ   : request presented to memory
    // S_WAIT  : request accepted, waiting for its response
    // S_HOLD  : instruction presented to decode
    // S_DRAIN : waiting for the response of a squashed request
    localparam logic [STATE_W-1:0] S_REQ   = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT  = 2'd1;
    localparam logic [STATE_W-1:0] S_HOLD  = 2'd2;
    localparam logic [STATE_W-1:0] S_DRAIN = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [31:0]        pc;
    logic               fault_q;

    logic [31:0]        redirect_target;
    logic               pc_misaligned;
    logic               req_valid_int;
    logic               req_handshake;
    logic               capture;
    logic               fault_beat;
    logic               accept;
    logic [31:0]        pc_after_fault;

    // ------------------------------------------------------------------------
    // Misaligned-target handling. A misaligned PC can only appear through a
    // redirect, so the PC's low bits double as the "fault beat pending" flag.
    // ------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign pc_misaligned   = (pc[1:0] != 2'b00);
    assign instr_fault     = fault_q;
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign pc_misaligned   = 1'b0;
    assign instr_fault     = 1'b0;
`endif

    // Events that move the datapath. A redirect masks all of them.
    assign req_handshake  = imem_req_valid & imem_req_ready;
    assign capture        = (state == S_WAIT) & imem_rsp_valid & ~redirect_valid;
    assign fault_beat     = (state == S_REQ) & pc_misaligned & ~redirect_valid;
    assign accept         = (state == S_HOLD) & instr_valid & instr_ready & ~redirect_valid;
    assign pc_after_fault = {pc[31:2], 2'b00} + 32'd4;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    // A request accepted on the redirect cycle is stale and
                    // its response must still be absorbed.
                    next_state = req_handshake ? S_DRAIN : S_REQ;
                end else if (req_handshake) begin
                    next_state = S_WAIT;
                end else if (fault_beat) begin
                    next_state = S_HOLD;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    next_state = redirect_valid ? S_REQ : S_HOLD;
                end else if (redirect_valid) begin
                    next_state = S_DRAIN;
                end
            end
            S_HOLD: begin
                // A redirect squashes the held instruction even when decode
                // is ready in the same cycle.
                if (redirect_valid || instr_ready) begin
                    next_state = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    next_state = S_REQ;
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        req_valid_int = 1'b0;
        if ((state == S_REQ) && !pc_misaligned) begin
            req_valid_int = 1'b1;
        end
    end

    // The request is gated by rst so nothing leaks out while the core is
    // held in reset, even though the state register already reads S_REQ.
    assign imem_req_valid = req_valid_int & ~rst;
    assign imem_req_addr  = pc;
    assign instr_op       = instr_data[6:0];

    // ------------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (capture) begin
            pc <= pc + 32'd4;
        end else if (accept && fault_q) begin
            pc <= pc_after_fault;
        end
    end

    // ------------------------------------------------------------------------
    // Decode-side output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr_data  <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            fault_q     <= 1'b0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            fault_q     <= 1'b0;
        end else if (capture) begin
            instr_valid <= 1'b1;
            instr_data  <= imem_rsp_data;
            instr_pc    <= pc;
            fault_q     <= 1'b0;
        end else if (fault_beat) begin
            // Synthetic NOP carrying the faulting (misaligned) target PC.
            instr_valid <= 1'b1;
            instr_data  <= NOP_INSTR;
            instr_pc    <= pc;
            fault_q     <= 1'b1;
        end else if (accept) begin
            instr_valid <= 1'b0;
            fault_q     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A per-cycle vector
//                table covers the normal fetch loop, decode stall, request
//                backpressure and redirects; hand sequences cover a squashed
//                long-latency fetch, PC wrap-around, misaligned redirect and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [6:0]  instr_op;
    logic        instr_fault;

    int tests_run;
    int tests_failed;

    // memory model state
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_op       (instr_op),
        .instr_fault    (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0033;
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_iv(input string name);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " wait"}, {31'd0, instr_valid}, 32'd1);
    endtask

    // Memory responder: latency counted in cycles from the accepted request.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_req_addr;
            end
        end
    end

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        irdy;
        logic        qrdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 32;
    vec_t v[NV];

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                                input logic irdy, input logic qrdy,
                                input logic erv, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] epc);
        vec_t t;
        t.redir = redir; t.rpc = rpc; t.irdy = irdy; t.qrdy = qrdy;
        t.e_rv = erv; t.e_addr = ea; t.e_iv = eiv; t.e_pc = epc;
        return t;
    endfunction

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        lat            = 1;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;

        //        redir rpc           irdy qrdy rv  addr          iv  pc
        v[0]  = mk(0, 32'h0,          1, 1,   1, 32'h100,       0, 32'h0);
        v[1]  = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[2]  = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h100);
        v[3]  = mk(0, 32'h0,          1, 1,   1, 32'h104,       0, 32'h0);
        v[4]  = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[5]  = mk(0, 32'h0,          0, 1,   0, 32'h0,         1, 32'h104);
        v[6]  = mk(0, 32'h0,          0, 1,   0, 32'h0,         1, 32'h104);
        v[7]  = mk(0, 32'h0,          0, 1,   0, 32'h0,         1, 32'h104);
        v[8]  = mk(0, 32'h0,          0, 1,   0, 32'h0,         1, 32'h104);
        v[9]  = mk(0, 32'h0,          0, 1,   0, 32'h0,         1, 32'h104);
        v[10] = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h104);
        v[11] = mk(0, 32'h0,          1, 0,   1, 32'h108,       0, 32'h0);
        v[12] = mk(0, 32'h0,          1, 1,   1, 32'h108,       0, 32'h0);
        v[13] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[14] = mk(1, 32'h200,        1, 1,   0, 32'h0,         1, 32'h108);
        v[15] = mk(0, 32'h0,          1, 1,   1, 32'h200,       0, 32'h0);
        v[16] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[17] = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h200);
        v[18] = mk(1, 32'h400,        1, 0,   1, 32'h204,       0, 32'h0);
        v[19] = mk(0, 32'h0,          1, 1,   1, 32'h400,       0, 32'h0);
        v[20] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[21] = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h400);
        v[22] = mk(1, 32'h500,        1, 1,   1, 32'h404,       0, 32'h0);
        v[23] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[24] = mk(0, 32'h0,          1, 1,   1, 32'h500,       0, 32'h0);
        v[25] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[26] = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h500);
        v[27] = mk(0, 32'h0,          1, 1,   1, 32'h504,       0, 32'h0);
        v[28] = mk(1, 32'h600,        1, 1,   0, 32'h0,         0, 32'h0);
        v[29] = mk(0, 32'h0,          1, 1,   1, 32'h600,       0, 32'h0);
        v[30] = mk(0, 32'h0,          1, 1,   0, 32'h0,         0, 32'h0);
        v[31] = mk(0, 32'h0,          1, 1,   0, 32'h0,         1, 32'h600);

        // ---------------- reset values ----------------
        @(negedge clk);
        @(negedge clk);
        chk("reset req_valid",   {31'd0, imem_req_valid}, 32'd0);
        chk("reset instr_valid", {31'd0, instr_valid},    32'd0);
        chk("reset instr_data",  instr_data,              32'd0);
        chk("reset instr_pc",    instr_pc,                32'd0);
        chk("reset instr_op",    {25'd0, instr_op},       32'd0);
        chk("reset instr_fault", {31'd0, instr_fault},    32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, v[i].e_rv});
            if (v[i].e_rv)
                chk($sformatf("vec%0d req_addr", i), imem_req_addr, v[i].e_addr);
            chk($sformatf("vec%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, v[i].e_iv});
            if (v[i].e_iv) begin
                chk($sformatf("vec%0d instr_pc", i),    instr_pc,            v[i].e_pc);
                chk($sformatf("vec%0d instr_data", i),  instr_data,          mem_data(v[i].e_pc));
                chk($sformatf("vec%0d instr_op", i),    {25'd0, instr_op},   {25'd0, mem_data(v[i].e_pc) & 32'h7F});
                chk($sformatf("vec%0d instr_fault", i), {31'd0, instr_fault}, 32'd0);
            end
            redirect_valid = v[i].redir;
            redirect_pc    = v[i].rpc;
            instr_ready    = v[i].irdy;
            imem_req_ready = v[i].qrdy;
        end

        // ---------------- A: redirect during a 3-cycle fetch ----------------
        begin
            int  found_at;
            found_at = -1;
            @(negedge clk);
            chk("A req_addr", imem_req_addr, 32'h604);
            lat = 3;
            @(negedge clk);
            chk("A waiting", {31'd0, imem_req_valid}, 32'd0);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h200;
            @(negedge clk);
            redirect_valid = 1'b0;
            for (int k = 0; k < 12; k++) begin
                chk("A no stale beat", {31'd0, instr_valid}, 32'd0);
                if (imem_req_valid) begin
                    found_at = k;
                    break;
                end
                @(negedge clk);
            end
            chk("A drain length", found_at, 32'd2);
            chk("A redirect addr", imem_req_addr, 32'h200);
            lat = 1;
            wait_iv("A beat");
            chk("A instr_pc",   instr_pc,   32'h200);
            chk("A instr_data", instr_data, mem_data(32'h200));
        end

        // ---------------- B: PC wrap-around ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("B squash",       {31'd0, instr_valid}, 32'd0);
        chk("B req_addr top", imem_req_addr,        32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        chk("B instr_pc",   instr_pc,   32'hFFFF_FFFC);
        chk("B instr_data", instr_data, mem_data(32'hFFFF_FFFC));
        @(negedge clk);
        chk("B wrap req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("B wrap req_addr",  imem_req_addr,           32'h0);

        // ---------------- C: misaligned redirect ----------------
        @(negedge clk);
        @(negedge clk);
        chk("C hold pc0", instr_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h302;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("C no request", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("C fault valid", {31'd0, instr_valid}, 32'd1);
        chk("C fault flag",  {31'd0, instr_fault}, 32'd1);
        chk("C fault pc",    instr_pc,             32'h302);
        chk("C fault data",  instr_data,           32'h0000_0013);
        chk("C fault op",    {25'd0, instr_op},    32'h13);
        @(negedge clk);
        chk("C next req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("C next req_addr",  imem_req_addr,           32'h304);
`else
        chk("C req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("C req_addr",  imem_req_addr,           32'h300);
        @(negedge clk);
        @(negedge clk);
        chk("C instr_pc",    instr_pc,             32'h300);
        chk("C instr_fault", {31'd0, instr_fault}, 32'd0);
`endif

        // ---------------- D: asynchronous reset ----------------
        wait_iv("D beat");
        rst = 1'b1;
        #1;
        chk("D async instr_valid", {31'd0, instr_valid},    32'd0);
        chk("D async instr_pc",    instr_pc,                32'd0);
        chk("D async req_valid",   {31'd0, imem_req_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the RV32I core. Owns the PC and issues word fetches to instruction memory over a valid/ready request plus response interface.
- Presents each fetched instruction, its PC and its opcode field to the decode stage (main_decoder consumes instr_op) over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards any stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response data valid; one response per accepted request, latency >= 1 cycle
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  redirect PC this cycle; highest priority
- redirect_pc  input  32  redirect target
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode accepts instruction
- instr_data  output  32  instruction word
- instr_pc  output  32  PC of instr_data
- instr_op  output  7  instr_data[6:0], opcode to main_decoder
- instr_fault  output  1  misaligned-fetch fault marker; see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=S_REQ.
  - imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, instr_op=0, instr_fault=0.
  - imem_req_valid is gated low while rst=1.
- At most one memory request outstanding. Four states:
  - S_REQ:
    - imem_req_valid=1, imem_req_addr=pc.
    - On req handshake -> S_WAIT.
    - Address and valid stay stable while not ready, unless a redirect occurs.
  - S_WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid: capture instr_data=rsp_data, instr_pc=pc; pc<=pc+4; -> S_HOLD.
    - instr_valid rises the cycle after the response.
  - S_HOLD:
    - instr_valid=1; instr_data, instr_pc and instr_op are held stable.
    - On instr_valid&&instr_ready: instr_valid<=0, -> S_REQ.
  - S_DRAIN:
    - Waits for the response of a squashed request.
    - On imem_rsp_valid: discard the data, -> S_REQ.
- Redirect (redirect_valid=1), any state, pc<=redirect_pc:
  - S_REQ without req handshake -> stay S_REQ; the next cycle presents the new address.
  - S_REQ with req handshake the same cycle -> S_DRAIN; that fetch is stale.
  - S_WAIT with rsp_valid the same cycle -> response discarded, -> S_REQ.
  - S_WAIT without rsp_valid -> S_DRAIN.
  - S_HOLD -> instr_valid<=0 even if instr_ready=1 that cycle (the held instruction is squashed), -> S_REQ.
  - S_DRAIN -> pc updated, remain S_DRAIN.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Throughput: 3 cycles/instruction with 1-cycle memory latency and instr_ready held at 1.
- imem_rsp_valid outside S_WAIT/S_DRAIN is a protocol error and is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect_pc with [1:0]!=0 issues no memory request.
  - It produces one S_HOLD beat with instr_fault=1, instr_pc=redirect_pc, instr_data=32'h0000_0013 (NOP), instr_op=7'b0010011.
  - After that beat is accepted, pc<=redirect_pc+4 with the low bits cleared.
- Undefined:
  - redirect_pc[1:0] is forced to 0.
  - instr_fault is tied 0.

Test Plan:
- Reset with RESET_PC=32'h100, 1-cycle memory returning 32'h00000033 -> imem_req_addr=0x100; instr_valid=1 with instr_pc=0x100, instr_op=7'b0110011; next request addr=0x104.
- instr_ready held 0 for 5 cycles in S_HOLD -> instr_valid, instr_data and instr_pc stable; no new request; release -> next request issued.
- Redirect to 0x200 while in S_WAIT, response arrives 3 cycles later -> that data is never presented; next request addr=0x200.
- Redirect in S_HOLD with instr_ready=1 the same cycle -> instruction squashed; next delivered instr_pc=redirect_pc.
- pc=32'hFFFF_FFFC fetched -> following request addr=32'h0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x302 -> no request; beat with instr_fault=1, instr_pc=0x302; next request addr=0x304. Without the macro -> request addr=0x300, instr_fault=0.
